alu_share_arb: RTL

//  Shares the single 8-bit carry-lookahead add/sub unit (A, B, op -> S, cout,

---
 rtl/alu_share_arb.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: round-robin arbiter that shares one combinational add/sub
// unit between two requesters. A granted operation drives registered operands
// to the adder for LAT settle cycles. The adder result is then registered and
// held for the winning requester until that requester consumes it.
module alu_share_arb #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    input  logic             r0_op,
    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    input  logic             r1_op,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_op,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_ovf,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_s,
    output logic             rsp_cout,
    output logic             rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Settle counter preload: the EXEC cycle with cnt==0 is the capture cycle.
    localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             add_op_q, add_op_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
    logic             rsp_cout_q, rsp_cout_d;
    logic             rsp_ovf_q, rsp_ovf_d;
    logic             id_q, id_d;
    logic             last_grant_q, last_grant_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             grant_valid_s;
    logic             grant_id_s;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_valid_s = 1'b0;
        grant_id_s    = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = ~last_grant_q;
        end else if (r0_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b0;
        end else if (r1_valid) begin
            grant_valid_s = 1'b1;
            grant_id_s    = 1'b1;
        end else begin
            grant_valid_s = 1'b0;
            grant_id_s    = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> EXEC on grant, EXEC -> RESP after settle, RESP -> IDLE on consume.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) state_d = EXEC;
                else               state_d = IDLE;
            end
            EXEC: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               state_d = EXEC;
            end
            RESP: begin
                if (rsp_ready[id_q]) state_d = IDLE;
                else                 state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, only to the current grant winner.
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if ((state_q == IDLE) && grant_valid_s) begin
            if (grant_id_s) r1_ready = 1'b1;
            else            r0_ready = 1'b1;
        end else begin
            r0_ready = 1'b0;
            r1_ready = 1'b0;
        end
    end

    // Datapath next values: latch operands on grant, capture result, release on consume.
    always_comb begin
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_op_d     = add_op_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_s_d      = rsp_s_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_ovf_d    = rsp_ovf_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid_s) begin
                    add_a_d      = grant_id_s ? r1_a  : r0_a;
                    add_b_d      = grant_id_s ? r1_b  : r0_b;
                    add_op_d     = grant_id_s ? r1_op : r0_op;
                    id_d         = grant_id_s;
                    last_grant_d = grant_id_s;
                    cnt_d        = LAT_M1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    rsp_s_d     = add_s;
                    rsp_cout_d  = add_cout;
                    rsp_ovf_d   = add_ovf;
                    rsp_valid_d = id_q ? 2'b10 : 2'b01;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready[id_q]) begin
                    rsp_valid_d = 2'b00;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
            end
        endcase
    end

    // Datapath registers; reset discards any in-flight transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a_q      <= '0;
            add_b_q      <= '0;
            add_op_q     <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_s_q      <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= 4'd0;
        end else begin
            add_a_q      <= add_a_d;
            add_b_q      <= add_b_d;
            add_op_q     <= add_op_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_s_q      <= rsp_s_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_ovf_q    <= rsp_ovf_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_op    = add_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_s     = rsp_s_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule
